ew_request_unit: RTL and testbench

- Front-end for the traffic controller's east-west request input: the opposite end of the carew/LightOut interface.
- Takes a raw active-low pushbutton or vehicle-loop contact, synchronizes and debounces it, then latches it as a request.
- Drives carew until the controller answers by showing GEW on LightOut; then re-arms after a cooldown.
- Also reports how long the request waited, in prescaled ticks.

---
 rtl/ew_request_unit.sv | 176 +++++++++++++++++
 tb/tb_ew_request_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ew_request_unit.sv
// ew_request_unit: east-west request front-end for the traffic controller.
// Synchronizes and debounces an active-low button/loop contact, then latches
// it as a request on carew until LightOut shows EW green. After the EW phase
// ends, the unit holds off for a cooldown before it accepts another press.
// It also reports the request wait time in prescaled ticks.
// Optional build macro: LIGHT_CHECK_EN adds the sticky light_err output.
module ew_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned COOLDOWN_CYCLES = 50000000,
  parameter int unsigned TICK_CYCLES     = 50000000,
  parameter logic [5:0]  GEW_CODE        = 6'b001100,
  parameter logic [5:0]  YEW_CODE        = 6'b001010,
  parameter logic [5:0]  GNS_CODE        = 6'b100001,
  parameter logic [5:0]  YNS_CODE        = 6'b010001,
  parameter logic [5:0]  ALLRED_CODE     = 6'b001001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_n,
  input  logic [5:0]  LightOut,
  output logic        carew,
  output logic        pending,
  output logic [15:0] wait_count
`ifdef LIGHT_CHECK_EN
  ,
  output logic        light_err
`endif
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int unsigned TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PENDING  = 2'd1;
  localparam logic [1:0] S_SERVED   = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  logic [1:0]      state_q, state_d;
  logic [15:0]     wc_q, wc_d;
  logic [TK_W-1:0] tick_q, tick_d;
  logic [CD_W-1:0] cool_q, cool_d;
  logic            carew_q, pending_q;

  // Two-flop synchronizer for the asynchronous contact; idles released (1).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: accept a new level only after it has differed for the full window;
  // a press is the accepting edge of a low level.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    press    = 1'b0;
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = sync2_q;
      db_cnt_d = '0;
      press    = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Request FSM with wait-time prescaler and cooldown timer.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    tick_d  = tick_q;
    cool_d  = cool_q;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          if (LightOut == GEW_CODE) begin
            state_d = S_SERVED;
          end else begin
            state_d = S_PENDING;
            wc_d    = '0;
            tick_d  = '0;
          end
        end
      end
      S_PENDING: begin
        if (LightOut == GEW_CODE) begin
          state_d = S_SERVED;
        end else if (tick_q == TK_LAST) begin
          tick_d = '0;
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_SERVED: begin
        if ((LightOut != GEW_CODE) && (LightOut != YEW_CODE)) begin
          state_d = S_COOLDOWN;
          cool_d  = '0;
        end
      end
      S_COOLDOWN: begin
        if (cool_q == CD_LAST) state_d = S_IDLE;
        else cool_d = cool_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM registers; carew/pending are decoded from the next state so they
  // change on the same edge as the state and come straight off a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wc_q      <= '0;
      tick_q    <= '0;
      cool_q    <= '0;
      carew_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      tick_q    <= tick_d;
      cool_q    <= cool_d;
      carew_q   <= (state_d == S_PENDING);
      pending_q <= (state_d == S_PENDING);
    end
  end

  assign carew      = carew_q;
  assign pending    = pending_q;
  assign wait_count = wc_q;

`ifdef LIGHT_CHECK_EN
  logic light_err_q;
  logic light_bad;

  assign light_bad = (LightOut != GNS_CODE) && (LightOut != YNS_CODE) &&
                     (LightOut != GEW_CODE) && (LightOut != YEW_CODE) &&
                     (LightOut != ALLRED_CODE);

  // Sticky flag for any light code outside the legal set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) light_err_q <= 1'b0;
    else        light_err_q <= light_err_q | light_bad;
  end

  assign light_err = light_err_q;
`endif

endmodule

// File: tb/tb_ew_request_unit.sv
// Testbench for ew_request_unit: directed scenarios plus a randomized run,
// all compared against a behavioural reference model of the request unit.
module tb_ew_request_unit;

  localparam int DEB  = 4;
  localparam int COOL = 8;
  localparam int TICK = 2;

  localparam logic [5:0] GEW    = 6'b001100;
  localparam logic [5:0] YEW    = 6'b001010;
  localparam logic [5:0] GNS    = 6'b100001;
  localparam logic [5:0] YNS    = 6'b010001;
  localparam logic [5:0] ALLRED = 6'b001001;

  localparam int P_IDLE = 0, P_PEND = 1, P_SERVED = 2, P_COOL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_n = 1'b1;
  logic [5:0]  LightOut = GNS;
  logic        carew;
  logic        pending;
  logic [15:0] wait_count;
`ifdef LIGHT_CHECK_EN
  logic        light_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic m_s1, m_s2, m_stable, m_err;
  int   m_run, m_phase, m_start, m_cool_start;
  int   m_wc;

  ew_request_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_CYCLES(COOL),
    .TICK_CYCLES(TICK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .LightOut(LightOut),
    .carew(carew),
    .pending(pending),
    .wait_count(wait_count)
`ifdef LIGHT_CHECK_EN
    ,
    .light_err(light_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_run = 0;
    m_phase = P_IDLE; m_wc = 0; m_start = 0; m_cool_start = 0; m_err = 1'b0;
  endtask

  // One clock edge of the behavioural model with inputs k/l present at the edge.
  task automatic model_edge(input logic k, input logic [5:0] l);
    logic pressed;
    pressed = 1'b0;
    // consecutive cycles the delayed input has disagreed with the accepted level
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_s2;
        m_run = 0;
        pressed = (m_s2 == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = k;
    case (m_phase)
      P_IDLE: if (pressed) begin
        if (l == GEW) m_phase = P_SERVED;
        else begin m_phase = P_PEND; m_start = cyc; m_wc = 0; end
      end
      P_PEND: begin
        if (l == GEW) m_phase = P_SERVED;
        else m_wc = ((cyc - m_start) / TICK > 65535) ? 65535 : (cyc - m_start) / TICK;
      end
      P_SERVED: if (l != GEW && l != YEW) begin m_phase = P_COOL; m_cool_start = cyc; end
      default: if (cyc - m_cool_start == COOL) m_phase = P_IDLE;
    endcase
    if (!(l inside {GNS, YNS, GEW, YEW, ALLRED})) m_err = 1'b1;
  endtask

  task automatic step(input logic k, input logic [5:0] l);
    key_n = k;
    LightOut = l;
    @(posedge clock);
    cyc++;
    model_edge(k, l);
    #1;
  endtask

  task automatic test_reset();
    key_n = 1'b1; LightOut = GNS; reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL reset_carew got %b exp 0", carew); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", pending); end
    checks++; if (wait_count !== 16'd0) begin errors++; $display("FAIL reset_wait got %0d exp 0", wait_count); end
    reset = 1'b1;
    repeat (4) step(1'b1, GNS);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL idle_carew got %b exp 0", carew); end
  endtask

  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    repeat (3) begin step(1'b0, GNS); seen |= carew; end
    step(1'b1, GNS); seen |= carew;
    repeat (2) begin step(1'b0, GNS); seen |= carew; end
    repeat (10) begin step(1'b1, GNS); seen |= carew; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bounce_no_request got %b exp 0", seen); end
  endtask

  task automatic test_press_and_serve();
    repeat (5) step(1'b0, GNS);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL press_edge5 got %b exp 0", carew); end
    step(1'b0, GNS);
    checks++; if (carew !== 1'b1) begin errors++; $display("FAIL press_edge6 got %b exp 1", carew); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL press_pending got %b exp 1", pending); end
    repeat (20) step(1'b0, GNS);
    checks++; if (wait_count !== 16'(m_wc)) begin errors++; $display("FAIL wait_model got %0d exp %0d", wait_count, m_wc); end
    step(1'b0, GEW);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL serve_carew got %b exp 0", carew); end
    checks++; if (wait_count !== 16'd10) begin errors++; $display("FAIL serve_wait got %0d exp 10", wait_count); end
    repeat (8) step(1'b1, GEW);
    checks++; if (wait_count !== 16'd10) begin errors++; $display("FAIL wait_hold got %0d exp 10", wait_count); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL served_pending got %b exp 0", pending); end
  endtask

  task automatic test_cooldown();
    logic seen;
    repeat (3) step(1'b1, YEW);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL yew_carew got %b exp 0", carew); end
    step(1'b1, ALLRED);
    seen = 1'b0;
    repeat (12) begin step(1'b0, ALLRED); seen |= carew; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cooldown_ignored got %b exp 0", seen); end
    repeat (8) step(1'b1, ALLRED);
    repeat (5) step(1'b0, GNS);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL rearm_edge5 got %b exp 0", carew); end
    step(1'b0, GNS);
    checks++; if (carew !== 1'b1) begin errors++; $display("FAIL rearm_carew got %b exp 1", carew); end
    checks++; if (wait_count !== 16'd0) begin errors++; $display("FAIL rearm_wait0 got %0d exp 0", wait_count); end
    repeat (2) step(1'b1, GNS);
    checks++; if (wait_count !== 16'd1) begin errors++; $display("FAIL rearm_wait1 got %0d exp 1", wait_count); end
    step(1'b1, GEW);
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL rearm_serve got %b exp 0", carew); end
    step(1'b1, ALLRED);
    repeat (8) step(1'b1, ALLRED);
  endtask

  task automatic test_press_while_gew();
    logic seen;
    seen = 1'b0;
    repeat (10) begin step(1'b0, GEW); seen |= carew; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL gew_press_carew got %b exp 0", seen); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL gew_press_pending got %b exp 0", pending); end
    step(1'b0, ALLRED);
    repeat (8) step(1'b1, ALLRED);
    repeat (6) step(1'b0, GNS);
    checks++; if (carew !== 1'b1) begin errors++; $display("FAIL after_cool_idle got %b exp 1", carew); end
  endtask

  task automatic test_reset_mid_pending();
    logic seen;
    repeat (4) step(1'b0, GNS);
    checks++; if (wait_count !== 16'd2) begin errors++; $display("FAIL mid_wait got %0d exp 2", wait_count); end
    key_n = 1'b1;
    reset = 1'b0;
    #2;
    checks++; if (carew !== 1'b0) begin errors++; $display("FAIL async_carew got %b exp 0", carew); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL async_pending got %b exp 0", pending); end
    checks++; if (wait_count !== 16'd0) begin errors++; $display("FAIL async_wait got %0d exp 0", wait_count); end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin step(1'b1, GNS); seen |= carew; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_survive got %b exp 0", seen); end
  endtask

`ifdef LIGHT_CHECK_EN
  task automatic test_light_err();
    checks++; if (light_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", light_err); end
    step(1'b1, 6'b111111);
    checks++; if (light_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", light_err); end
    repeat (5) step(1'b1, GNS);
    checks++; if (light_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", light_err); end
    reset = 1'b0;
    #2;
    checks++; if (light_err !== 1'b0) begin errors++; $display("FAIL err_reset got %b exp 0", light_err); end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
`endif

  task automatic test_random();
    logic [5:0] codes [5];
    int key_left, light_left;
    logic k;
    logic [5:0] l;
    codes[0] = GNS; codes[1] = YNS; codes[2] = GEW; codes[3] = YEW; codes[4] = ALLRED;
    key_left = 0; light_left = 0; k = 1'b1; l = GNS;
    for (int i = 0; i < 3000; i++) begin
      if (key_left == 0) begin k = 1'($urandom_range(0, 1)); key_left = $urandom_range(1, 9); end
      if (light_left == 0) begin l = codes[$urandom_range(0, 4)]; light_left = $urandom_range(1, 40); end
      key_left--; light_left--;
      step(k, l);
      checks++;
      if (carew !== (m_phase == P_PEND)) begin
        errors++; $display("FAIL rand_carew cyc=%0d got %b exp %b", cyc, carew, (m_phase == P_PEND));
      end
      checks++;
      if (pending !== (m_phase == P_PEND)) begin
        errors++; $display("FAIL rand_pending cyc=%0d got %b exp %b", cyc, pending, (m_phase == P_PEND));
      end
      checks++;
      if (wait_count !== 16'(m_wc)) begin
        errors++; $display("FAIL rand_wait cyc=%0d got %0d exp %0d", cyc, wait_count, m_wc);
      end
`ifdef LIGHT_CHECK_EN
      checks++;
      if (light_err !== m_err) begin
        errors++; $display("FAIL rand_err cyc=%0d got %b exp %b", cyc, light_err, m_err);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press_and_serve();
    test_cooldown();
    test_press_while_gew();
    test_reset_mid_pending();
`ifdef LIGHT_CHECK_EN
    test_light_err();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
